fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Downstream consumer of a normal-mode synchronous FIFO: read latency 1 cycle, `dout` held between reads.
- Pops words from the FIFO and presents them on a valid/ready master stream.
- Uses a 2-entry output buffer so the stream sustains 1 word/cycle under back-pressure.
- Frames the stream into fixed-length packets (`m_last`) and counts completed packets.

Parameters:
- DW, 8, data width; must match the FIFO data width.
- PKT_LEN, 16, words per packet; must be ≥1.
- PCW, 16, width of the packet counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  permits issuing new FIFO reads.
- fifo_dout  in  DW  FIFO read data, valid the cycle after `fifo_read`.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  out  1  FIFO read strobe.
- m_data  out  DW  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the sink.
- m_last  out  1  final word of a packet.
- beat_idx  out  $clog2(PKT_LEN)max1  index of the current word within its packet.
- pkt_cnt  out  PCW  number of completed packets, wraps modulo 2^PCW.

Behaviour:
- Interface (already decided): one clock, `clk`; reset `rst_n` is synchronous and active-low.
- Reset values:
  - All state is cleared while `rst_n`=0 at a clock edge: buffer count, inflight flag, `beat_idx`, `pkt_cnt`.
  - Outputs: `m_valid`=0, `m_last`=0, `beat_idx`=0, `pkt_cnt`=0, `m_data`=0.
  - `fifo_read` is gated combinationally by `rst_n`, so it is 0 throughout reset.
- State:
  - `cnt`: buffered words, 0..2.
  - `infl`: 1 when a read was issued last cycle, i.e. `infl` <= `fifo_read`.
  - `occ` = `cnt` + `infl`.
  - `pop` = `m_valid` & `m_ready`.
- Read issue:
  - `fifo_read` = `rst_n` & `en` & ~`fifo_empty` & (`occ` < 2 | (`occ` == 2 & `pop`)).
  - This is combinational from `m_ready`, `fifo_empty` and `en`; the sink and FIFO registers must tolerate that path.
- Capture: when `infl`=1, `fifo_dout` is written into the buffer at that edge.
- Buffer update on simultaneous capture and pop:
  - Head is popped and the new word is written behind it.
  - `cnt` is unchanged.
  - Order is strictly FIFO.
- Latency: `fifo_read` high in cycle N → `fifo_dout` valid in N+1 → captured at end of N+1 → `m_valid`=1 with that word in cycle N+2.
- Throughput: 1 word/cycle sustained while FIFO is non-empty, `en`=1 and `m_ready`=1.
- Stream outputs:
  - `m_valid` = (`cnt` != 0).
  - `m_data` = buffer head.
  - `m_data` and `m_last` hold stable while `m_valid` & ~`m_ready`.
  - `m_valid` never drops without a pop.
- Overflow: `occ` never exceeds 2 and `cnt` never exceeds 2. A capture with `cnt`=2 and no pop is illegal and is a bench assertion.
- Framing:
  - `m_last` = `m_valid` & (`beat_idx` == PKT_LEN-1).
  - On `pop`: `beat_idx` increments, wrapping to 0 after PKT_LEN-1.
  - On `pop` & `m_last`: `pkt_cnt` increments, wrapping modulo 2^PCW.
  - PKT_LEN=1: `m_last` = `m_valid` every beat.
- `en` deassert: no new reads from the next evaluation; the inflight word and buffered words (at most 2) are still delivered normally.
- `fifo_empty` asserted: no read; any inflight word is still captured.
- Reset mid-operation:
  - Buffered and inflight words are discarded; an inflight word already popped from the FIFO is lost (documented, acceptable).
  - Framing restarts at `beat_idx`=0.
- Underflow: impossible by construction, since `fifo_read` requires ~`fifo_empty`.

Test Plan:
1. Streaming:
   - Stimulus: PKT_LEN=4, FIFO preloaded with 20 words 0x00..0x13, `en`=1, `m_ready`=1, release reset.
   - Response: first `fifo_read` in the first cycle after release; `m_valid` 2 cycles later; 20 consecutive beats 0x00..0x13 with no gaps.
   - `m_last` on words 0x03, 0x07, 0x0B, 0x0F, 0x13; final `pkt_cnt`=5.
2. Back-pressure:
   - Stimulus: same data, `m_ready` pattern 1,0,0,1,0,1…
   - Response: all 20 words delivered in order, none dropped or duplicated; `m_data`/`m_last` stable during stalls; assertion `occ`≤2 never fires.
3. Sparse input:
   - Stimulus: FIFO empty; single write of 0xA5; later single write of 0x3C.
   - Response: `fifo_read` low while empty; each word appears as one beat 2 cycles after its `fifo_read`; `beat_idx` goes 0→1→2.
4. Enable drop:
   - Stimulus: continuous streaming with `m_ready`=0, then deassert `en`.
   - Response: `fifo_read`=0 thereafter; after `m_ready` returns to 1, exactly `occ` (≤2) further beats, then `m_valid`=0.
5. Reset mid-packet:
   - Stimulus: assert `rst_n`=0 for 1 cycle at `beat_idx`=2, `pkt_cnt`=3.
   - Response: next cycle `m_valid`=0, `beat_idx`=0, `pkt_cnt`=0; after release, streaming resumes and `m_last` falls on the 4th beat after reset.
6. PKT_LEN=1:
   - Stimulus: 8 words streamed with `m_ready`=1.
   - Response: `m_last`=1 on every beat; `pkt_cnt`=8; `beat_idx` constant 0.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of fifo_stream_reader.
interface fifo_stream_reader_if #(
  parameter int DW = 8
);
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_read;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_read, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_read, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a latency-1 synchronous FIFO into a 2-deep skid buffer and presents it as a
// framed valid/ready stream with fixed-length packets and a completed-packet counter.
module fifo_stream_reader #(
  parameter  int DW      = 8,
  parameter  int PKT_LEN = 16,
  parameter  int PCW     = 16,
  localparam int BW      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic [BW-1:0]        beat_idx,
  output logic [PCW-1:0]       pkt_cnt
);

  localparam logic [BW-1:0] LAST_IDX = BW'(PKT_LEN - 1);

  logic [1:0]    cnt;
  logic [1:0]    occ;
  logic          infl;
  logic          pop;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;

  assign occ         = cnt + {1'b0, infl};
  assign bus.m_valid = (cnt != 2'd0);
  assign pop         = bus.m_valid & bus.m_ready;
  assign bus.m_data  = head;
  assign bus.m_last  = bus.m_valid & (beat_idx == LAST_IDX);

  // A slot freed by this cycle's pop may be refilled by a read issued in the same cycle.
  assign bus.fifo_read = rst_n & en & ~bus.fifo_empty &
                         ((occ < 2'd2) | ((occ == 2'd2) & pop));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      infl     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      beat_idx <= '0;
      pkt_cnt  <= '0;
    end else begin
      infl <= bus.fifo_read;

      unique case ({infl, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= bus.fifo_dout;
          else             tail <= bus.fifo_dout;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            head <= tail;
            tail <= bus.fifo_dout;
          end else begin
            head <= bus.fifo_dout;
          end
        end
        default: ;
      endcase

      if (pop) begin
        beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + BW'(1);
        if (bus.m_last) pkt_cnt <= pkt_cnt + PCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: a queue-based FIFO and stream model drive
// two instances (PKT_LEN=4 and PKT_LEN=1) with shared stimulus and check every cycle.
module tb_fifo_stream_reader;
  localparam int DW  = 8;
  localparam int LA  = 4;
  localparam int PCA = 16;
  localparam int LB  = 1;
  localparam int PCB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           en;
  logic [1:0]     bia;
  logic [PCA-1:0] pca;
  logic [0:0]     bib;
  logic [PCB-1:0] pcb;

  fifo_stream_reader_if #(.DW(DW)) ifa ();
  fifo_stream_reader_if #(.DW(DW)) ifb ();

  fifo_stream_reader #(.DW(DW), .PKT_LEN(LA), .PCW(PCA)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(ifa), .beat_idx(bia), .pkt_cnt(pca)
  );
  fifo_stream_reader #(.DW(DW), .PKT_LEN(LB), .PCW(PCB)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(ifb), .beat_idx(bib), .pkt_cnt(pcb)
  );

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   rdy;
  } ent_t;

  logic [DW-1:0] fifo_q[$];
  ent_t          exp_q[$];
  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  int unsigned   cyc = 0;
  int unsigned   beats = 0;
  int unsigned   delivered = 0;
  int unsigned   first_pop = 0;
  int unsigned   last_pop = 0;
  int            dut_occ = 0;
  int            max_occ = 0;
  int unsigned   ready_mode = 0;
  int unsigned   pat_idx = 0;
  logic          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_ready(input logic r);
    ifa.m_ready = r;
    ifb.m_ready = r;
  endtask

  task automatic update_empty();
    ifa.fifo_empty = (fifo_q.size() == 0);
    ifb.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    update_empty();
  endtask

  // One clock: check outputs mid-cycle against the model, then advance model and FIFO.
  task automatic step();
    logic exp_valid, exp_pop, exp_read, rd_a, act_pop;
    int   occ;
    ent_t e;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
    exp_pop   = exp_valid && ifa.m_ready;
    occ       = exp_q.size();
    exp_read  = rst_n && en && (fifo_q.size() > 0) &&
                ((occ < 2) || (occ == 2 && exp_pop));

    check_eq("a_read",  {31'd0, ifa.fifo_read}, {31'd0, exp_read});
    check_eq("a_valid", {31'd0, ifa.m_valid},   {31'd0, exp_valid});
    check_eq("a_last",  {31'd0, ifa.m_last},    {31'd0, exp_valid && (beats % LA == LA - 1)});
    check_eq("a_beat",  32'(bia), beats % LA);
    check_eq("a_pcnt",  32'(pca), (beats / LA) % (1 << PCA));
    check_eq("b_read",  {31'd0, ifb.fifo_read}, {31'd0, exp_read});
    check_eq("b_valid", {31'd0, ifb.m_valid},   {31'd0, exp_valid});
    check_eq("b_last",  {31'd0, ifb.m_last},    {31'd0, exp_valid});
    check_eq("b_beat",  32'(bib), 32'd0);
    check_eq("b_pcnt",  32'(pcb), (beats / LB) % (1 << PCB));
    if (exp_valid) begin
      check_eq("a_data", 32'(ifa.m_data), 32'(exp_q[0].d));
      check_eq("b_data", 32'(ifb.m_data), 32'(exp_q[0].d));
    end

    rd_a    = ifa.fifo_read;
    act_pop = ifa.m_valid & ifa.m_ready;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      beats   = 0;
      dut_occ = 0;
    end else begin
      if (exp_pop) begin
        void'(exp_q.pop_front());
        beats++;
        delivered++;
        if (delivered == 1) first_pop = cyc;
        last_pop = cyc;
      end
      if (rd_a && fifo_q.size() > 0) begin
        e.d   = fifo_q[0];
        e.rdy = cyc + 1;
        exp_q.push_back(e);
      end
      dut_occ = dut_occ + int'(rd_a) - int'(act_pop);
      if (dut_occ > max_occ) max_occ = dut_occ;
    end
    #1;
    if (rd_a && fifo_q.size() > 0) begin
      ifa.fifo_dout = fifo_q.pop_front();
      ifb.fifo_dout = ifa.fifo_dout;
    end
    update_empty();
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0: set_ready(1'b1);
      1: begin set_ready(pat[pat_idx % 6]); pat_idx++; end
      2: set_ready($urandom_range(0, 1) == 1);
      default: ;
    endcase
  endtask

  task automatic run_to(input string tag, input int unsigned target, input int unsigned bound);
    int unsigned n = 0;
    while (delivered < target && n < bound) begin
      drive_ready();
      step();
      n++;
    end
    check_eq(tag, delivered, target);
  endtask

  initial begin
    int unsigned d0;
    rst_n = 1'b0;
    en    = 1'b1;
    set_ready(1'b1);
    ifa.fifo_dout = '0;
    ifb.fifo_dout = '0;
    update_empty();

    // Streaming at full rate
    for (int i = 0; i < 20; i++) push_word(DW'(i));
    repeat (3) step();
    check_eq("rst_data_a", 32'(ifa.m_data), 32'd0);
    check_eq("rst_data_b", 32'(ifb.m_data), 32'd0);
    rst_n = 1'b1;
    ready_mode = 0;
    run_to("t1_delivered", 20, 60);
    check_eq("t1_no_gaps", last_pop - first_pop, 32'd19);
    check_eq("t1_pkt_a", 32'(pca), 32'd5);
    check_eq("t1_pkt_b", 32'(pcb), 32'd4);

    // Back-pressure pattern 1,0,0,1,0,1
    for (int i = 0; i < 20; i++) push_word(DW'(i));
    ready_mode = 1;
    run_to("t2_delivered", 40, 200);
    check_eq("t2_pkt_a", 32'(pca), 32'd10);

    // Sparse input
    ready_mode = 0;
    repeat (3) step();
    push_word(8'hA5);
    repeat (6) step();
    push_word(8'h3C);
    repeat (6) step();
    check_eq("t3_delivered", delivered, 32'd42);
    check_eq("t3_beat", 32'(bia), 32'd2);

    // Enable drop while stalled
    ready_mode = 3;
    set_ready(1'b0);
    for (int i = 0; i < 10; i++) push_word(DW'(8'h50 + i));
    repeat (6) step();
    en = 1'b0;
    repeat (4) step();
    d0 = delivered;
    set_ready(1'b1);
    repeat (6) step();
    check_eq("t4_drain_beats", delivered - d0, 32'd2);
    check_eq("t4_idle_valid", {31'd0, ifa.m_valid}, 32'd0);
    en = 1'b1;

    // Randomized traffic
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < 16 && $urandom_range(0, 2) == 0) push_word(DW'($urandom));
      drive_ready();
      step();
    end
    en = 1'b1;
    ready_mode = 0;
    run_to("t5_drain", delivered + fifo_q.size() + exp_q.size(), 100);

    // Reset mid-packet
    for (int i = 0; i < 30; i++) push_word(DW'(8'hC0 + i));
    for (int i = 0; i < 40 && !(bia == 2'd2 && pca >= 16'd3); i++) step();
    check_eq("t6_pre_beat", 32'(bia), 32'd2);
    rst_n = 1'b0;
    step();
    check_eq("t6_rst_valid", {31'd0, ifa.m_valid}, 32'd0);
    check_eq("t6_rst_beat",  32'(bia), 32'd0);
    check_eq("t6_rst_pkt",   32'(pca), 32'd0);
    rst_n = 1'b1;
    d0 = delivered;
    run_to("t6_eight", d0 + 8, 40);
    check_eq("t6_pkt_b", 32'(pcb), 32'd8);
    check_eq("t6_pkt_a", 32'(pca), 32'd2);
    run_to("t6_drain", delivered + fifo_q.size() + exp_q.size(), 100);

    check_eq("occ_max_le2", {31'd0, max_occ <= 2}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
endmodule
